// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 hex keypad: scan states, column constants and the
// row/column-to-hex key encoding used by the scanner and downstream decoders.
package keypad_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StScan0,
        StScan1,
        StScan2,
        StScan3,
        StHold
    } state_e;

    localparam logic [3:0] COL_ALL = 4'b1111;

    // Lowest active row wins; code is {row_index, col_index}.
    function automatic logic [3:0] encode_key(input logic [3:0] row, input logic [1:0] col_idx);
        logic [1:0] r;
        if (row[0]) begin
            r = 2'd0;
        end else if (row[1]) begin
            r = 2'd1;
        end else if (row[2]) begin
            r = 2'd2;
        end else begin
            r = 2'd3;
        end
        return {r, col_idx};
    endfunction

endpackage

// File: rtl/keypad_scan_fsm.sv
// Column-scanning keypad controller: wakes on the synchronized row flag, walks the columns
// to locate the key, reports a registered hex code, then waits for a debounced release.
module keypad_scan_fsm
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] row,
    input  logic       s_row,
    output logic [3:0] col,
    output logic [3:0] code,
    output logic       valid,
    output logic       key_strobe
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

    state_e          state_q, state_d;
    logic [3:0]      code_q, code_d;
    logic            valid_q, valid_d;
    logic            strobe_q, strobe_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      col_idx;
    logic            scanning;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            code_q   <= 4'h0;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        code_d   = code_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        cnt_d    = cnt_q;
        col_idx  = 2'd0;
        scanning = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (s_row) begin
                    state_d = StScan0;
                end
            end
            StScan0: begin
                scanning = 1'b1;
                col_idx  = 2'd0;
                state_d  = StScan1;
            end
            StScan1: begin
                scanning = 1'b1;
                col_idx  = 2'd1;
                state_d  = StScan2;
            end
            StScan2: begin
                scanning = 1'b1;
                col_idx  = 2'd2;
                state_d  = StScan3;
            end
            StScan3: begin
                scanning = 1'b1;
                col_idx  = 2'd3;
                // Empty scan across all columns: back to idle, outputs untouched.
                state_d  = StIdle;
            end
            StHold: begin
                if (s_row) begin
                    cnt_d = '0;
                end else if (cnt_q == CntLast) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (scanning && (row != 4'b0000)) begin
            state_d  = StHold;
            code_d   = encode_key(row, col_idx);
            valid_d  = 1'b1;
            strobe_d = 1'b1;
            cnt_d    = '0;
        end
    end

    // Column drive depends on the state register only, never on row.
    always_comb begin
        unique case (state_q)
            StScan0: col = 4'b0001;
            StScan1: col = 4'b0010;
            StScan2: col = 4'b0100;
            StScan3: col = 4'b1000;
            default: col = COL_ALL;
        endcase
    end

    assign code       = code_q;
    assign valid      = valid_q;
    assign key_strobe = strobe_q;

endmodule

// File: tb/tb_keypad_scan_fsm.sv
// Directed bench for keypad_scan_fsm: a table of single-press vectors plus hand-written
// sequences for reset, bounce-during-release and back-to-back presses.
module tb_keypad_scan_fsm;

    logic       clock;
    logic       reset;
    logic [3:0] row;
    logic       s_row;
    logic [3:0] col;
    logic [3:0] code;
    logic       valid;
    logic       key_strobe;

    logic [15:0] keys;  // bit 4*r+c set = key (r,c) held down
    int checks = 0;
    int errors = 0;
    int strobe_cnt = 0;

    keypad_scan_fsm #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .row       (row),
        .s_row     (s_row),
        .col       (col),
        .code      (code),
        .valid     (valid),
        .key_strobe(key_strobe)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Keypad matrix: a row reads 1 only when a held key's column is driven.
    always_comb begin
        row = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4*r+c] && col[c]) row[r] = 1'b1;
            end
        end
    end

    always @(posedge clock) begin
        if (key_strobe) strobe_cnt <= strobe_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  exp_code;
        int          exp_col;  // -1: spurious wake
    } vec_t;

    vec_t vecs[6];
    logic [3:0] last_code;
    int s0;

    initial begin
        vecs[0] = '{16'h0200, 4'h9, 1};              // r2 c1
        vecs[1] = '{16'h8080, 4'h7, 3};              // rows 1 and 3 on c3
        vecs[2] = '{16'h0001, 4'h0, 0};              // r0 c0
        vecs[3] = '{16'h8000, 4'hF, 3};              // r3 c3
        vecs[4] = '{16'h2040, 4'hD, 1};              // r3c1 beats r1c2
        vecs[5] = '{16'h0000, 4'h0, -1};             // spurious

        keys  = 16'h0;
        s_row = 1'b0;
        reset = 1'b1;
        #1;
        check("reset_col", col, 4'b1111);
        check("reset_code", code, 4'h0);
        check("reset_valid", valid, 1'b0);
        check("reset_strobe", key_strobe, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle_col", col, 4'b1111);
        last_code = 4'h0;

        for (int i = 0; i < 6; i++) begin
            keys  = vecs[i].keys;
            s_row = 1'b1;
            s0 = strobe_cnt;
            tick();  // edge N
            if (vecs[i].exp_col < 0) begin
                s_row = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("v%0d_col%0d", i, k), col, 4'b0001 << k);
                    check($sformatf("v%0d_strobe%0d", i, k), key_strobe, 1'b0);
                    tick();
                end
                check($sformatf("v%0d_idle_col", i), col, 4'b1111);
                check($sformatf("v%0d_code", i), code, last_code);
                check($sformatf("v%0d_valid", i), valid, 1'b0);
                tick();
                check($sformatf("v%0d_nostrobe", i), strobe_cnt - s0, 0);
            end else begin
                for (int k = 0; k <= vecs[i].exp_col; k++) begin
                    check($sformatf("v%0d_col%0d", i, k), col, 4'b0001 << k);
                    check($sformatf("v%0d_prestrobe%0d", i, k), key_strobe, 1'b0);
                    tick();
                end
                check($sformatf("v%0d_strobe", i), key_strobe, 1'b1);
                check($sformatf("v%0d_valid", i), valid, 1'b1);
                check($sformatf("v%0d_code", i), code, vecs[i].exp_code);
                check($sformatf("v%0d_hold_col", i), col, 4'b1111);
                tick();
                check($sformatf("v%0d_strobe_off", i), key_strobe, 1'b0);
                last_code = vecs[i].exp_code;
                keys  = 16'h0;
                s_row = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    check($sformatf("v%0d_rel_valid%0d", i, j), valid, 1'b1);
                    tick();
                end
                check($sformatf("v%0d_released", i), valid, 1'b0);
                check($sformatf("v%0d_code_kept", i), code, last_code);
                check($sformatf("v%0d_one_strobe", i), strobe_cnt - s0, 1);
            end
        end

        // Bounce in HOLD: 3 low, 1 high, then 4 low.
        keys  = 16'h0020;  // r1 c1 -> 5
        s_row = 1'b1;
        tick();
        tick();
        tick();
        check("bounce_press_code", code, 4'h5);
        check("bounce_press_strobe", key_strobe, 1'b1);
        s0 = strobe_cnt;
        keys  = 16'h0;
        s_row = 1'b0;
        for (int j = 0; j < 3; j++) tick();
        check("bounce_valid_a", valid, 1'b1);
        s_row = 1'b1;
        tick();
        check("bounce_valid_b", valid, 1'b1);
        s_row = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            check($sformatf("bounce_valid_low%0d", j), valid, 1'b1);
        end
        tick();
        check("bounce_released", valid, 1'b0);
        check("bounce_code_kept", code, 4'h5);
        check("bounce_no_restrobe", strobe_cnt - s0, 1);

        // Back-to-back: release key 0, press F right after IDLE is entered.
        keys  = 16'h0001;
        s_row = 1'b1;
        tick();
        tick();
        check("b2b_first_code", code, 4'h0);
        check("b2b_first_strobe", key_strobe, 1'b1);
        keys  = 16'h0;
        s_row = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        check("b2b_first_released", valid, 1'b0);
        keys  = 16'h8000;
        s_row = 1'b1;
        tick();  // edge N
        check("b2b_scan0", col, 4'b0001);
        for (int j = 0; j < 3; j++) begin
            tick();
            check($sformatf("b2b_nostrobe%0d", j), key_strobe, 1'b0);
        end
        tick();  // edge N+4
        check("b2b_strobe", key_strobe, 1'b1);
        check("b2b_code", code, 4'hF);
        check("b2b_valid", valid, 1'b1);
        keys  = 16'h0;
        s_row = 1'b0;
        for (int j = 0; j < 4; j++) tick();
        check("b2b_released", valid, 1'b0);

        // Asynchronous reset during SCAN2 while code holds F.
        keys  = 16'h8000;
        s_row = 1'b1;
        tick();
        tick();
        tick();
        check("rst_pre_col", col, 4'b0100);
        check("rst_pre_code", code, 4'hF);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_col", col, 4'b1111);
        check("rst_async_code", code, 4'h0);
        check("rst_async_valid", valid, 1'b0);
        check("rst_async_strobe", key_strobe, 1'b0);
        keys  = 16'h0;
        s_row = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        check("rst_after_col", col, 4'b1111);
        check("rst_after_valid", valid, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
